// File: rtl/phy_loopback_model.sv
// Behavioural transceiver bank: loops the TX word back as RX with per-lane bit
// skew, bit-slip and polarity control, plus the tx/rx ready handshake.
module phy_loopback_model #(
  parameter int DWIDTH       = 512,
  parameter int NUM_LANES    = 16,
  parameter int TX_READY_DLY = 8,
  parameter int RX_READY_DLY = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DWIDTH-1:0]                                 phy_data_tx_link2phy,
  input  logic [NUM_LANES-1:0]                              phy_bit_slip,
  input  logic [NUM_LANES-1:0]                              phy_lane_polarity,
  input  logic                                              phy_init_cont_set,
  input  logic [NUM_LANES*$clog2(DWIDTH/NUM_LANES)-1:0]     lane_skew,
  output logic [DWIDTH-1:0]                                 phy_data_rx_phy2link,
  output logic                                              phy_tx_ready,
  output logic                                              phy_rx_ready,
  output logic [NUM_LANES*$clog2(DWIDTH/NUM_LANES)-1:0]     slip_offset
);

  localparam int LW   = DWIDTH / NUM_LANES;
  localparam int OW   = $clog2(LW);
  localparam int OW1  = OW + 1;
  localparam int MAXD = (TX_READY_DLY > RX_READY_DLY) ? TX_READY_DLY : RX_READY_DLY;
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [1:0] {
    T_WAIT,
    R_WAIT,
    READY
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DWIDTH-1:0]   s1_q, s1_d;
  logic [DWIDTH-1:0]   hist_q;
  logic [DWIDTH-1:0]   out_q, out_d;
  logic [DWIDTH-1:0]   pol_mask;
  logic [NUM_LANES*OW-1:0] offset_q, offset_d;
  logic [2*LW-1:0]     win;
  logic [OW:0]         shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One counter serves both waits; it is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      T_WAIT: begin
        if (cnt_q == CW'(TX_READY_DLY - 1)) begin
          state_d = R_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_WAIT: begin
        if (!phy_init_cont_set) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(RX_READY_DLY - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READY: begin
        if (!phy_init_cont_set) begin
          state_d = R_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = T_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    phy_tx_ready = (state_q != T_WAIT);
    phy_rx_ready = (state_q == READY);
  end

  always_comb begin
    pol_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pol_mask[i*LW +: LW] = {LW{phy_lane_polarity[i]}};
    end
    s1_d = phy_data_tx_link2phy ^ pol_mask;
  end

  // A window of the current and previous lane word; sliding it down by the
  // offset delays the bit stream by that many bit times.
  always_comb begin
    out_d = '0;
    win   = '0;
    shamt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      win   = {s1_q[i*LW +: LW], hist_q[i*LW +: LW]};
      shamt = OW1'(LW) - {1'b0, offset_q[i*OW +: OW]};
      out_d[i*LW +: LW] = win[shamt +: LW];
    end
  end

  always_comb begin
    offset_d = offset_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (phy_rx_ready && phy_bit_slip[i]) begin
        offset_d[i*OW +: OW] = offset_q[i*OW +: OW] + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      hist_q   <= '0;
      out_q    <= '0;
      offset_q <= lane_skew;
    end else begin
      s1_q     <= s1_d;
      hist_q   <= s1_q;
      out_q    <= out_d;
      offset_q <= offset_d;
    end
  end

  always_comb begin
    phy_data_rx_phy2link = phy_rx_ready ? out_q : '0;
    slip_offset          = offset_q;
  end

endmodule

// File: tb/tb_phy_loopback_model.sv
// Directed bench for phy_loopback_model: ready handshake, loopback, polarity,
// skew/slip, ready drop and mid-run reset, checked through a scoreboard queue.
module tb_phy_loopback_model;

  localparam int DW = 512;
  localparam int NL = 16;
  localparam int LW = 32;
  localparam int OW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   tx;
  logic [NL-1:0]   slip;
  logic [NL-1:0]   pol;
  logic            initSet;
  logic [NL*OW-1:0] skew;
  logic [DW-1:0]   rx;
  logic            txReady;
  logic            rxReady;
  logic [NL*OW-1:0] soff;

  logic [DW-1:0]   expQ[$];
  int              vectors = 0;
  int              miscompares = 0;

  logic [DW-1:0]   w;
  logic [DW-1:0]   expW;
  logic [NL*OW-1:0] expSoff;
  int              off;

  phy_loopback_model dut (
    .clk                  (clk),
    .rst                  (rst),
    .phy_data_tx_link2phy (tx),
    .phy_bit_slip         (slip),
    .phy_lane_polarity    (pol),
    .phy_init_cont_set    (initSet),
    .lane_skew            (skew),
    .phy_data_rx_phy2link (rx),
    .phy_tx_ready         (txReady),
    .phy_rx_ready         (rxReady),
    .slip_offset          (soff)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] polMask(input logic [NL-1:0] p);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < NL; i++) begin
      if (p[i]) m[i*LW +: LW] = '1;
    end
    return m;
  endfunction

  function automatic logic [LW-1:0] rotl(input logic [LW-1:0] x, input int k);
    return (x << k) | (x >> (LW - k));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] txw, input logic [DW-1:0] expw);
    tx = txw;
    expQ.push_back(expw);
    step();
    if (expQ.size() == 2) checkOutput("stream", rx, expQ.pop_front());
  endtask

  task automatic drain();
    step();
    if (expQ.size() != 0) checkOutput("stream_last", rx, expQ.pop_front());
  endtask

  initial begin
    rst     = 1'b1;
    tx      = '0;
    slip    = '0;
    pol     = '0;
    initSet = 1'b1;
    skew    = '0;

    // Reset state and ready handshake with all-ones traffic already flowing
    stepN(2);
    checkOutput("reset_rx", rx, '0);
    checkOutput("reset_txr", DW'(txReady), '0);
    checkOutput("reset_rxr", DW'(rxReady), '0);
    checkOutput("reset_soff", DW'(soff), DW'(skew));
    rst = 1'b0;
    tx  = '1;
    stepN(7);
    checkOutput("txr_edge7", DW'(txReady), '0);
    step();
    checkOutput("txr_edge8", DW'(txReady), DW'(1));
    stepN(15);
    checkOutput("rxr_edge23", DW'(rxReady), '0);
    checkOutput("rx_gated", rx, '0);
    step();
    checkOutput("rxr_edge24", DW'(rxReady), DW'(1));

    // Straight loopback: incrementing words then random per-lane words
    for (int k = 1; k <= 8; k++) applyStimulus(DW'(k), DW'(k));
    drain();
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < NL; j++) w[j*LW +: LW] = $urandom;
      applyStimulus(w, w);
    end
    drain();

    // Polarity
    pol = 16'h0005;
    for (int k = 0; k < 4; k++) applyStimulus('0, polMask(16'h0005));
    drain();
    pol = 16'h8130;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < NL; j++) w[j*LW +: LW] = $urandom;
      applyStimulus(w, w ^ polMask(16'h8130));
    end
    drain();
    pol = '0;

    // Skew of 4 on lane 3, reloaded by reset
    skew[3*OW +: OW] = 5'd4;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("skew_reset_soff", DW'(soff), DW'(skew));
    checkOutput("skew_reset_rx", rx, '0);
    w = '0;
    w[0*LW +: LW] = 32'h1234_5678;
    w[3*LW +: LW] = 32'hA5A5_A5A5;
    tx = w;
    stepN(24);
    checkOutput("skew_rxr", DW'(rxReady), DW'(1));
    expW = w;
    expW[3*LW +: LW] = 32'h5A5A_5A5A;
    for (int k = 0; k < 3; k++) applyStimulus(w, expW);
    drain();

    // 28 slips on lane 3: offset walks 5..31 then wraps to 0
    for (int k = 1; k <= 28; k++) begin
      off  = (4 + k) % LW;
      slip = 16'h0008;
      step();
      slip = '0;
      checkOutput("slip_off", DW'(soff[3*OW +: OW]), DW'(off));
      step();
      checkOutput("slip_data", DW'(rx[3*LW +: LW]), DW'(rotl(32'hA5A5_A5A5, off)));
    end
    checkOutput("slip_wrap_word", rx, w);

    // Simultaneous slips on lanes 1 and 5
    slip = 16'h0022;
    step();
    slip = '0;
    expSoff = '0;
    expSoff[1*OW +: OW] = 5'd1;
    expSoff[5*OW +: OW] = 5'd1;
    checkOutput("multi_slip", DW'(soff), DW'(expSoff));

    // Ready drop for one cycle; slip while not ready is ignored
    initSet = 1'b0;
    step();
    checkOutput("drop_rxr", DW'(rxReady), '0);
    checkOutput("drop_rx", rx, '0);
    initSet = 1'b1;
    slip    = 16'h0008;
    step();
    slip = '0;
    checkOutput("drop_slip_ignored", DW'(soff), DW'(expSoff));
    stepN(14);
    checkOutput("drop_rxr_15", DW'(rxReady), '0);
    step();
    checkOutput("drop_rxr_16", DW'(rxReady), DW'(1));
    checkOutput("drop_rx_back", rx, w);

    // Mid-run reset after slips: offsets reload and ready restarts
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid_rst_rx", rx, '0);
    checkOutput("mid_rst_txr", DW'(txReady), '0);
    checkOutput("mid_rst_rxr", DW'(rxReady), '0);
    checkOutput("mid_rst_soff", DW'(soff), DW'(skew));
    stepN(8);
    checkOutput("mid_rst_txr8", DW'(txReady), DW'(1));
    stepN(16);
    checkOutput("mid_rst_rxr24", DW'(rxReady), DW'(1));
    checkOutput("mid_rst_data", rx, expW);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
